// File: rtl/gpr_ctrl_pkg.sv
// Shared types and constants for the GPR writeback controller.
// Optional checking logic in gpr_wb_ctrl is enabled by defining GPR_WB_CHECK_EN.
package gpr_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32'd2 ** REG_ADDR_W;

    // Writeback source encoding, also the round-robin pointer type.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

    // One writeback request as presented by an execution unit.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // One-hot mask selecting a single register.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

    // The source that gets priority after the given one has been served.
    function automatic wb_src_e other_src(input wb_src_e src);
        wb_src_e nxt;
        case (src)
            SRC_ALU: nxt = SRC_LSU;
            SRC_LSU: nxt = SRC_ALU;
            default: nxt = SRC_ALU;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy scoreboard. A bit is set when an instruction with that
// destination issues and cleared when its writeback reaches the GPR.
// A set and a clear of the same register on one edge leaves it busy,
// since the set belongs to a newer producer. x0 is never busy.
module gpr_scoreboard
    import gpr_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic                  any_busy
);

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic [NUM_REGS-1:0] busy_nxt_s;

    // Next busy vector: clear first, then set, so set wins on a collision.
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        if (set_en && (set_addr != {REG_ADDR_W{1'b0}})) begin
            set_mask_s = reg_onehot(set_addr);
        end else begin
            set_mask_s = '0;
        end
        if (clr_en) begin
            clr_mask_s = reg_onehot(clr_addr);
        end else begin
            clr_mask_s = '0;
        end
        busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s)
                     & ~reg_onehot({REG_ADDR_W{1'b0}});
    end

    // Busy vector state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Bit 0 is held at zero, so x0 operands never report busy.
    assign any_busy = busy_r[rs1_addr] | busy_r[rs2_addr] | busy_r[rd_addr];
    assign busy_vec = busy_r;

endmodule

// File: rtl/gpr_wb_ctrl.sv
// GPR write-port controller: round-robin arbitration of ALU/LSU writebacks
// onto the single GPR write port (parked on x0 when idle) plus a busy
// scoreboard for RAW/WAW stalls at decode.
// Define GPR_WB_CHECK_EN to build the sticky writeback-error checker
// (orphan writeback and stuck-WAW watchdog); otherwise wb_err_out is 0.
module gpr_wb_ctrl
    import gpr_ctrl_pkg::*;
(
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  issue_valid_in,
    input  logic [REG_ADDR_W-1:0] issue_rd_addr_in,
    input  logic [REG_ADDR_W-1:0] issue_rs1_addr_in,
    input  logic [REG_ADDR_W-1:0] issue_rs2_addr_in,
    output logic                  hazard_out,
    input  logic                  alu_valid_in,
    input  logic [REG_ADDR_W-1:0] alu_rd_addr_in,
    input  logic [XLEN-1:0]       alu_data_in,
    output logic                  alu_ready_out,
    input  logic                  lsu_valid_in,
    input  logic [REG_ADDR_W-1:0] lsu_rd_addr_in,
    input  logic [XLEN-1:0]       lsu_data_in,
    output logic                  lsu_ready_out,
    output logic [REG_ADDR_W-1:0] gpr_rd_addr_out,
    output logic [XLEN-1:0]       gpr_rd_data_out,
    output logic [NUM_REGS-1:0]   busy_vec_out,
    output logic                  wb_err_out
);

    wb_req_t               alu_req_s;
    wb_req_t               lsu_req_s;
    wb_req_t               win_req_s;
    wb_src_e               rr_ptr_r;
    logic                  grant_alu_s;
    logic                  grant_lsu_s;
    logic                  rr_flip_s;
    logic                  hs_s;
    logic                  any_busy_s;
    logic                  issue_acc_s;
    logic                  pend_valid_r;
    logic [REG_ADDR_W-1:0] pend_addr_r;
    logic                  clr_en_s;

    assign alu_req_s = {alu_valid_in, alu_rd_addr_in, alu_data_in};
    assign lsu_req_s = {lsu_valid_in, lsu_rd_addr_in, lsu_data_in};

    // Arbitration: a lone requester wins; on contention rr_ptr decides and flips.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_lsu_s = 1'b0;
        rr_flip_s   = 1'b0;
        win_req_s   = '0;
        case ({alu_req_s.valid, lsu_req_s.valid})
            2'b10: grant_alu_s = 1'b1;
            2'b01: grant_lsu_s = 1'b1;
            2'b11: begin
                rr_flip_s = 1'b1;
                if (rr_ptr_r == SRC_ALU) begin
                    grant_alu_s = 1'b1;
                end else begin
                    grant_lsu_s = 1'b1;
                end
            end
            default: begin
                grant_alu_s = 1'b0;
                grant_lsu_s = 1'b0;
            end
        endcase
        if (grant_alu_s) begin
            win_req_s = alu_req_s;
        end else if (grant_lsu_s) begin
            win_req_s = lsu_req_s;
        end else begin
            win_req_s = '0;
        end
    end

    // Readies are forced low while reset is held so no handshake is seen.
    assign alu_ready_out = grant_alu_s & reset_in;
    assign lsu_ready_out = grant_lsu_s & reset_in;
    assign hs_s          = win_req_s.valid & reset_in;

    assign hazard_out  = issue_valid_in & any_busy_s;
    assign issue_acc_s = issue_valid_in & ~any_busy_s;
    assign clr_en_s    = pend_valid_r;

    gpr_scoreboard u_scoreboard (
        .clk      (clock_in),
        .rst_n    (reset_in),
        .set_en   (issue_acc_s),
        .set_addr (issue_rd_addr_in),
        .clr_en   (clr_en_s),
        .clr_addr (pend_addr_r),
        .rs1_addr (issue_rs1_addr_in),
        .rs2_addr (issue_rs2_addr_in),
        .rd_addr  (issue_rd_addr_in),
        .busy_vec (busy_vec_out),
        .any_busy (any_busy_s)
    );

    // Round-robin pointer, moved only when both sources contended.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            rr_ptr_r <= SRC_ALU;
        end else if (rr_flip_s) begin
            rr_ptr_r <= other_src(rr_ptr_r);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // GPR write port and pending-clear tracking; idle cycles write 0 to x0.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            gpr_rd_addr_out <= '0;
            gpr_rd_data_out <= '0;
            pend_valid_r    <= 1'b0;
            pend_addr_r     <= '0;
        end else if (hs_s) begin
            gpr_rd_addr_out <= win_req_s.rd_addr;
            gpr_rd_data_out <= win_req_s.data;
            pend_valid_r    <= 1'b1;
            pend_addr_r     <= win_req_s.rd_addr;
        end else begin
            gpr_rd_addr_out <= '0;
            gpr_rd_data_out <= '0;
            pend_valid_r    <= 1'b0;
            pend_addr_r     <= '0;
        end
    end

`ifdef GPR_WB_CHECK_EN
    logic [7:0] wd_cnt_r;
    logic       wd_cond_s;
    logic       orphan_s;
    logic       err_r;

    assign wd_cond_s = issue_valid_in & hazard_out & busy_vec_out[issue_rd_addr_in];
    assign orphan_s  = hs_s
                       & (win_req_s.rd_addr != {REG_ADDR_W{1'b0}})
                       & ~busy_vec_out[win_req_s.rd_addr]
                       & ~(clr_en_s & (pend_addr_r == win_req_s.rd_addr));

    // Watchdog counting consecutive cycles issue is stuck on a busy destination.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            wd_cnt_r <= 8'd0;
        end else if (wd_cond_s) begin
            if (wd_cnt_r != 8'hFF) begin
                wd_cnt_r <= wd_cnt_r + 8'd1;
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
        end else begin
            wd_cnt_r <= 8'd0;
        end
    end

    // Sticky error flag: orphan writeback or watchdog expiry.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            err_r <= 1'b0;
        end else if (orphan_s || (wd_cond_s && (wd_cnt_r == 8'hFF))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign wb_err_out = err_r;
`else
    assign wb_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed self-checking bench for gpr_wb_ctrl.
module tb_gpr_wb_ctrl;

    logic        clock_in;
    logic        reset_in;
    logic        issue_valid_in;
    logic [4:0]  issue_rd_addr_in;
    logic [4:0]  issue_rs1_addr_in;
    logic [4:0]  issue_rs2_addr_in;
    logic        hazard_out;
    logic        alu_valid_in;
    logic [4:0]  alu_rd_addr_in;
    logic [31:0] alu_data_in;
    logic        alu_ready_out;
    logic        lsu_valid_in;
    logic [4:0]  lsu_rd_addr_in;
    logic [31:0] lsu_data_in;
    logic        lsu_ready_out;
    logic [4:0]  gpr_rd_addr_out;
    logic [31:0] gpr_rd_data_out;
    logic [31:0] busy_vec_out;
    logic        wb_err_out;

    int checks = 0;
    int errors = 0;

    gpr_wb_ctrl dut (
        .clock_in          (clock_in),
        .reset_in          (reset_in),
        .issue_valid_in    (issue_valid_in),
        .issue_rd_addr_in  (issue_rd_addr_in),
        .issue_rs1_addr_in (issue_rs1_addr_in),
        .issue_rs2_addr_in (issue_rs2_addr_in),
        .hazard_out        (hazard_out),
        .alu_valid_in      (alu_valid_in),
        .alu_rd_addr_in    (alu_rd_addr_in),
        .alu_data_in       (alu_data_in),
        .alu_ready_out     (alu_ready_out),
        .lsu_valid_in      (lsu_valid_in),
        .lsu_rd_addr_in    (lsu_rd_addr_in),
        .lsu_data_in       (lsu_data_in),
        .lsu_ready_out     (lsu_ready_out),
        .gpr_rd_addr_out   (gpr_rd_addr_out),
        .gpr_rd_data_out   (gpr_rd_data_out),
        .busy_vec_out      (busy_vec_out),
        .wb_err_out        (wb_err_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic test_reset();
        alu_valid_in = 1'b1;
        alu_rd_addr_in = 5'd3;
        #1;
        checks++; if (busy_vec_out !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", busy_vec_out, 32'h0); end
        checks++; if (gpr_rd_addr_out !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", gpr_rd_addr_out); end
        checks++; if (gpr_rd_data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", gpr_rd_data_out); end
        checks++; if (alu_ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", alu_ready_out); end
        checks++; if (wb_err_out !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", wb_err_out); end
        alu_valid_in = 1'b0;
        alu_rd_addr_in = 5'd0;
        @(negedge clock_in);
        reset_in = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (gpr_rd_addr_out !== 5'd0 || busy_vec_out !== 32'h0 || hazard_out !== 1'b0) begin
                errors++; $display("FAIL idle_cycle%0d got addr %0d busy %h haz %b exp 0/0/0", i, gpr_rd_addr_out, busy_vec_out, hazard_out);
            end
        end
    endtask

    task automatic test_raw_hazard();
        issue_valid_in = 1'b1; issue_rd_addr_in = 5'd5;
        issue_rs1_addr_in = 5'd0; issue_rs2_addr_in = 5'd0;
        #1;
        checks++; if (hazard_out !== 1'b0) begin errors++; $display("FAIL raw_first_issue got %b exp 0", hazard_out); end
        tick();
        checks++; if (busy_vec_out !== 32'h0000_0020) begin errors++; $display("FAIL raw_busy_set got %h exp %h", busy_vec_out, 32'h20); end
        issue_rd_addr_in = 5'd6; issue_rs1_addr_in = 5'd5;
        alu_valid_in = 1'b1; alu_rd_addr_in = 5'd5; alu_data_in = 32'hDEAD_BEEF;
        #1;
        checks++; if (hazard_out !== 1'b1) begin errors++; $display("FAIL raw_hazard got %b exp 1", hazard_out); end
        checks++; if (alu_ready_out !== 1'b1) begin errors++; $display("FAIL raw_alu_ready got %b exp 1", alu_ready_out); end
        tick();
        alu_valid_in = 1'b0;
        #1;
        checks++; if (gpr_rd_addr_out !== 5'd5 || gpr_rd_data_out !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL raw_wb got %0d/%h exp 5/deadbeef", gpr_rd_addr_out, gpr_rd_data_out);
        end
        checks++; if (busy_vec_out !== 32'h0000_0020 || hazard_out !== 1'b1) begin
            errors++; $display("FAIL raw_still_busy got %h/%b exp 00000020/1", busy_vec_out, hazard_out);
        end
        tick();
        checks++; if (busy_vec_out !== 32'h0 || hazard_out !== 1'b0 || gpr_rd_addr_out !== 5'd0) begin
            errors++; $display("FAIL raw_cleared got busy %h haz %b addr %0d exp 0/0/0", busy_vec_out, hazard_out, gpr_rd_addr_out);
        end
        issue_valid_in = 1'b0; issue_rs1_addr_in = 5'd0; issue_rd_addr_in = 5'd0;
        tick();
        checks++; if (busy_vec_out !== 32'h0) begin errors++; $display("FAIL raw_no_issue got %h exp 0", busy_vec_out); end
    endtask

    task automatic test_round_robin();
        logic        av [5]; logic [4:0] aa [5]; logic [31:0] ad [5];
        logic        lv [5]; logic [4:0] la [5]; logic [31:0] ld [5];
        logic        er_a [5]; logic er_l [5];
        logic [4:0]  ea [5]; logic [31:0] ed [5];
        av = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        aa = '{5'd1, 5'd2, 5'd2, 5'd10, 5'd10};
        ad = '{32'h1111_1111, 32'h2222_2222, 32'h2222_2222, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
        lv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        la = '{5'd3, 5'd3, 5'd4, 5'd4, 5'd0};
        ld = '{32'h3333_3333, 32'h3333_3333, 32'h4444_4444, 32'h4444_4444, 32'h0};
        er_a = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        er_l = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ea = '{5'd1, 5'd3, 5'd2, 5'd4, 5'd10};
        ed = '{32'h1111_1111, 32'h3333_3333, 32'h2222_2222, 32'h4444_4444, 32'hAAAA_AAAA};
        for (int i = 0; i < 5; i++) begin
            alu_valid_in = av[i]; alu_rd_addr_in = aa[i]; alu_data_in = ad[i];
            lsu_valid_in = lv[i]; lsu_rd_addr_in = la[i]; lsu_data_in = ld[i];
            #1;
            checks++; if (alu_ready_out !== er_a[i] || lsu_ready_out !== er_l[i]) begin
                errors++; $display("FAIL rr_ready%0d got alu %b lsu %b exp alu %b lsu %b", i, alu_ready_out, lsu_ready_out, er_a[i], er_l[i]);
            end
            tick();
            checks++; if (gpr_rd_addr_out !== ea[i] || gpr_rd_data_out !== ed[i]) begin
                errors++; $display("FAIL rr_write%0d got %0d/%h exp %0d/%h", i, gpr_rd_addr_out, gpr_rd_data_out, ea[i], ed[i]);
            end
        end
        alu_valid_in = 1'b0; lsu_valid_in = 1'b0;
        tick();
        checks++; if (gpr_rd_addr_out !== 5'd0 || gpr_rd_data_out !== 32'h0 || busy_vec_out !== 32'h0) begin
            errors++; $display("FAIL rr_park got %0d/%h busy %h exp 0/0/0", gpr_rd_addr_out, gpr_rd_data_out, busy_vec_out);
        end
    endtask

    task automatic test_set_wins();
        alu_valid_in = 1'b1; alu_rd_addr_in = 5'd7; alu_data_in = 32'h7777_7777;
        tick();
        alu_valid_in = 1'b0;
        issue_valid_in = 1'b1; issue_rd_addr_in = 5'd7;
        issue_rs1_addr_in = 5'd0; issue_rs2_addr_in = 5'd0;
        #1;
        checks++; if (hazard_out !== 1'b0 || gpr_rd_addr_out !== 5'd7) begin
            errors++; $display("FAIL setwin_pre got haz %b addr %0d exp 0/7", hazard_out, gpr_rd_addr_out);
        end
        tick();
        issue_valid_in = 1'b0;
        checks++; if (busy_vec_out !== 32'h0000_0080) begin errors++; $display("FAIL setwin_busy got %h exp %h", busy_vec_out, 32'h80); end
    endtask

    task automatic test_async_reset();
        for (int r = 4; r <= 6; r++) begin
            issue_valid_in = 1'b1; issue_rd_addr_in = 5'(r);
            tick();
        end
        issue_valid_in = 1'b0;
        checks++; if (busy_vec_out !== 32'h0000_00F0) begin errors++; $display("FAIL arst_setup got %h exp %h", busy_vec_out, 32'hF0); end
        alu_valid_in = 1'b1; alu_rd_addr_in = 5'd4; alu_data_in = 32'h4444_4444;
        tick();
        alu_rd_addr_in = 5'd5; alu_data_in = 32'h5555_5555;
        issue_valid_in = 1'b1; issue_rd_addr_in = 5'd8;
        #1;
        checks++; if (gpr_rd_addr_out !== 5'd4 || alu_ready_out !== 1'b1) begin
            errors++; $display("FAIL arst_pending got addr %0d rdy %b exp 4/1", gpr_rd_addr_out, alu_ready_out);
        end
        reset_in = 1'b0;
        #1;
        checks++; if (busy_vec_out !== 32'h0 || gpr_rd_addr_out !== 5'd0 || gpr_rd_data_out !== 32'h0) begin
            errors++; $display("FAIL arst_regs got busy %h addr %0d data %h exp 0/0/0", busy_vec_out, gpr_rd_addr_out, gpr_rd_data_out);
        end
        checks++; if (alu_ready_out !== 1'b0 || hazard_out !== 1'b0 || wb_err_out !== 1'b0) begin
            errors++; $display("FAIL arst_comb got rdy %b haz %b err %b exp 0/0/0", alu_ready_out, hazard_out, wb_err_out);
        end
        alu_valid_in = 1'b0; issue_valid_in = 1'b0;
        #1;
        reset_in = 1'b1;
        tick();
        issue_valid_in = 1'b1; issue_rd_addr_in = 5'd4;
        #1;
        checks++; if (hazard_out !== 1'b0) begin errors++; $display("FAIL arst_reissue_haz got %b exp 0", hazard_out); end
        tick();
        issue_valid_in = 1'b0;
        checks++; if (busy_vec_out !== 32'h0000_0010) begin errors++; $display("FAIL arst_reissue_busy got %h exp %h", busy_vec_out, 32'h10); end
    endtask

    task automatic test_wb_err();
        logic exp_err;
`ifdef GPR_WB_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        lsu_valid_in = 1'b1; lsu_rd_addr_in = 5'd9; lsu_data_in = 32'h9999_9999;
        #1;
        checks++; if (lsu_ready_out !== 1'b1) begin errors++; $display("FAIL err_lsu_ready got %b exp 1", lsu_ready_out); end
        tick();
        lsu_valid_in = 1'b0;
        checks++; if (wb_err_out !== exp_err) begin errors++; $display("FAIL err_flag got %b exp %b", wb_err_out, exp_err); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (wb_err_out !== exp_err) begin errors++; $display("FAIL err_sticky got %b exp %b", wb_err_out, exp_err); end
    endtask

    initial begin
        reset_in = 1'b0;
        issue_valid_in = 1'b0; issue_rd_addr_in = 5'd0;
        issue_rs1_addr_in = 5'd0; issue_rs2_addr_in = 5'd0;
        alu_valid_in = 1'b0; alu_rd_addr_in = 5'd0; alu_data_in = 32'h0;
        lsu_valid_in = 1'b0; lsu_rd_addr_in = 5'd0; lsu_data_in = 32'h0;
        #12;
        test_reset();
        test_idle();
        test_raw_hazard();
        test_round_robin();
        test_set_wins();
        test_async_reset();
        test_wb_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
